// File: rtl/arbiter_n.sv
// Fixed-priority n-way arbiter. The lowest index (vector MSB) has the highest priority.
// The grant is purely combinational; a registered copy of the grant, its binary index
// and a valid flag are also provided, each with one cycle of latency.
module arbiter_n #(
  parameter int unsigned n = 8,
  localparam int unsigned IW = (n > 1) ? $clog2(n) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:n-1]  r,
  output logic [0:n-1]  g,
  output logic [0:n-1]  g_q,
  output logic          any_req,
  output logic [IW-1:0] idx_q,
  output logic          valid_q
);

  logic [IW-1:0] idx_d;

  // Priority grant: a bit wins only if no lower-index request has been seen yet.
  // A known 1 on a higher-priority bit forces every lower grant bit to 0, even if
  // those lower request bits are X/Z.
  always_comb begin
    logic found;
    found = 1'b0;
    g     = '0;
    for (int unsigned i = 0; i < n; i++) begin
      g[i]  = r[i] & ~found;
      found = found | r[i];
    end
  end

  // Request summary, independent of reset.
  always_comb begin
    any_req = |r;
  end

  // Binary index of the one-hot grant; 0 when nothing is granted.
  always_comb begin
    idx_d = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (g[i]) begin
        idx_d = IW'(i);
      end
    end
  end

  // Registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      g_q     <= g;
      idx_q   <= idx_d;
      valid_q <= any_req;
    end
  end

endmodule

// File: tb/tb_arbiter_n.sv
// Directed self-checking bench for arbiter_n (n = 8, plus n = 1 and n = 3 instances).
module tb_arbiter_n;

  logic       clk;
  logic       rst_n;

  logic [0:7] r8;
  logic [0:7] g8;
  logic [0:7] g_q8;
  logic       any8;
  logic [2:0] idx8;
  logic       valid8;

  logic [0:0] r1;
  logic [0:0] g1;
  logic [0:0] g_q1;
  logic       any1;
  logic [0:0] idx1;
  logic       valid1;

  logic [0:2] r3;
  logic [0:2] g3;
  logic [0:2] g_q3;
  logic       any3;
  logic [1:0] idx3;
  logic       valid3;

  int unsigned n_checks;
  int unsigned n_fails;

  arbiter_n #(.n(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .r       (r8),
    .g       (g8),
    .g_q     (g_q8),
    .any_req (any8),
    .idx_q   (idx8),
    .valid_q (valid8)
  );

  arbiter_n #(.n(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .r       (r1),
    .g       (g1),
    .g_q     (g_q1),
    .any_req (any1),
    .idx_q   (idx1),
    .valid_q (valid1)
  );

  arbiter_n #(.n(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .r       (r3),
    .g       (g3),
    .g_q     (g_q3),
    .any_req (any3),
    .idx_q   (idx3),
    .valid_q (valid3)
  );

  always #5 clk = ~clk;

  // Expected grant as an integer: the most significant set bit of k within w bits.
  function automatic logic [31:0] pri_model(input int unsigned k, input int unsigned w);
    logic [31:0] kv;
    kv = 32'(k);
    for (int b = 31; b >= 0; b--) begin
      if (b < int'(w) && kv[b]) return 32'(1) << b;
    end
    return 32'(0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    r8       = 8'hFF;
    r1       = 1'b0;
    r3       = 3'b000;

    // Reset held for two edges with all requests active.
    tick();
    tick();
    chk("rst_g_q", 32'(g_q8), 32'h00);
    chk("rst_idx_q", 32'(idx8), 32'd0);
    chk("rst_valid_q", 32'(valid8), 32'd0);
    chk("rst_g_comb", 32'(g8), 32'h80);
    chk("rst_any_req", 32'(any8), 32'd1);

    // Release: first edge loads from current r.
    rst_n = 1'b1;
    tick();
    chk("rel_g_q", 32'(g_q8), 32'h80);
    chk("rel_idx_q", 32'(idx8), 32'd0);
    chk("rel_valid_q", 32'(valid8), 32'd1);

    // r[5] only.
    r8 = 8'b00000100;
    tick();
    chk("b5_g_q", 32'(g_q8), 32'h04);
    chk("b5_idx_q", 32'(idx8), 32'd5);
    chk("b5_valid_q", 32'(valid8), 32'd1);

    // Lowest priority requester.
    r8 = 8'b00000001;
    tick();
    chk("b7_idx_q", 32'(idx8), 32'd7);
    chk("b7_g_q", 32'(g_q8), 32'h01);

    // Mixed request: r[3] wins.
    r8 = 8'b00010110;
    tick();
    chk("mix_idx_q", 32'(idx8), 32'd3);
    chk("mix_g_q", 32'(g_q8), 32'h10);

    // No requests.
    r8 = 8'b00000000;
    tick();
    chk("zero_g_q", 32'(g_q8), 32'h00);
    chk("zero_idx_q", 32'(idx8), 32'd0);
    chk("zero_valid_q", 32'(valid8), 32'd0);
    chk("zero_any_req", 32'(any8), 32'd0);

    // Directed combinational vectors.
    r8 = 8'b00000000; #1 chk("c_00", 32'(g8), 32'h00);
    chk("c_00_any", 32'(any8), 32'd0);
    r8 = 8'b00000001; #1 chk("c_01", 32'(g8), 32'h01);
    r8 = 8'b10110000; #1 chk("c_b0", 32'(g8), 32'h80);
    r8 = 8'b00010110; #1 chk("c_16", 32'(g8), 32'h10);
    r8 = 8'b11111111; #1 chk("c_ff", 32'(g8), 32'h80);
    chk("c_ff_any", 32'(any8), 32'd1);

    // Known higher-priority 1 masks unknown lower bits.
    r8 = 8'b01xxxxxx; #1 chk("c_x", 32'(g8), 32'h40);

    // Exhaustive n=8 sweep.
    for (int k = 0; k < 256; k++) begin
      r8 = 8'(k);
      #1;
      chk("sweep8_g", 32'(g8), pri_model(k, 8));
      chk("sweep8_any", 32'(any8), (k != 0) ? 32'd1 : 32'd0);
    end

    // Reset re-asserted mid-run does not affect g.
    @(negedge clk);
    r8 = 8'b00100000;
    rst_n = 1'b0;
    tick();
    chk("rst2_g_q", 32'(g_q8), 32'h00);
    chk("rst2_valid_q", 32'(valid8), 32'd0);
    chk("rst2_g_comb", 32'(g8), 32'h20);
    rst_n = 1'b1;
    tick();
    chk("rst2_idx_q", 32'(idx8), 32'd2);
    chk("rst2_valid_rel", 32'(valid8), 32'd1);

    // n=1: g = r, valid follows with one cycle latency, idx stays 0.
    r1 = 1'b1; #1 chk("n1_g_hi", 32'(g1), 32'd1);
    tick();
    chk("n1_valid_hi", 32'(valid1), 32'd1);
    chk("n1_idx_hi", 32'(idx1), 32'd0);
    chk("n1_g_q_hi", 32'(g_q1), 32'd1);
    r1 = 1'b0; #1 chk("n1_g_lo", 32'(g1), 32'd0);
    chk("n1_any_lo", 32'(any1), 32'd0);
    tick();
    chk("n1_valid_lo", 32'(valid1), 32'd0);

    // n=3 exhaustive sweep, combinational and registered.
    for (int k = 0; k < 8; k++) begin
      r3 = 3'(k);
      #1;
      chk("sweep3_g", 32'(g3), pri_model(k, 3));
      tick();
      chk("sweep3_g_q", 32'(g_q3), pri_model(k, 3));
      chk("sweep3_valid", 32'(valid3), (k != 0) ? 32'd1 : 32'd0);
      chk("sweep3_idx", 32'(idx3), (k >= 4) ? 32'd0 : (k >= 2) ? 32'd1 : (k == 1) ? 32'd2 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/arbiter_n.md
ARBITER_N -- requirements
Module: arbiter_n

Interface
REQ-001: Parameter n, default 8, SHALL set the number of requesters; legal range n >= 1.
REQ-002: Derived width IW = max(1, ceil(log2(n))) SHALL size the encoded-index output.
REQ-003: clk  input  1  SHALL be the single clock; all registered outputs update on its rising edge.
REQ-004: rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005: r  input  [0:n-1]  SHALL carry request lines; r[0] is the vector MSB and has the highest priority.
REQ-006: g  output  [0:n-1]  SHALL carry the combinational one-hot-or-zero grant, bit-aligned with r.
REQ-007: g_q  output  [0:n-1]  SHALL carry g registered by one clk cycle.
REQ-008: any_req  output  1  SHALL be the combinational OR of all bits of r.
REQ-009: idx_q  output  [IW-1:0]  SHALL carry the registered binary index of the granted bit.
REQ-010: valid_q  output  1  SHALL carry any_req registered by one clk cycle.

Function
REQ-011: g SHALL be purely combinational from r; it SHALL NOT depend on clk, rst_n or internal state.
REQ-012: g[i] SHALL be 1 iff r[i]=1 and r[j]=0 for all j<i; all other bits of g SHALL be 0.
REQ-013: r all-zero SHALL give g all-zero; g SHALL never have more than one bit set.
REQ-014: g SHALL settle within one simulation time unit of any change on r, with no glitch-dependent state.
REQ-015: Applying integer k to r (r = k) SHALL make r[n-1] the LSB of k and r[0] the MSB; the highest-priority grant therefore goes to the most significant set bit of k.
REQ-016: On each rising clk edge with rst_n=1: g_q <= g, valid_q <= any_req, idx_q <= index i of the set bit of g.
REQ-017: When g is all-zero, idx_q SHALL load 0 and valid_q SHALL load 0.
REQ-018: For n=1: g = r, idx_q is constant 0, valid_q follows r[0] with one cycle of latency.
REQ-019: Registered outputs SHALL have exactly one cycle of latency relative to r sampled at the edge; there is no handshake or back-pressure.
REQ-020: The arbiter SHALL have no fairness or rotation state; priority is fixed by index.
REQ-021: If r contains X/Z bits, g SHALL equal the result the exact priority rule gives for the known higher-priority bits; when such a bit is 1, lower bits of g SHALL be 0.

Reset
REQ-022: While rst_n=0 at a rising clk edge: g_q <= 0, idx_q <= 0, valid_q <= 0.
REQ-023: Reset SHALL NOT affect g or any_req, which continue to follow r combinationally.
REQ-024: On the first rising edge with rst_n=1, the registered outputs SHALL load from the current r per REQ-016.
REQ-025: Registered output values before the first reset edge are undefined; the bench SHALL NOT check them.

Verification (n=8 unless stated)
REQ-026: Exhaustive sweep r = 0..255, checking g 1 time unit after each change against the REQ-012 model -> zero mismatches; with !== comparison, X is a failure.
REQ-027: r=8'b00000000 -> g=8'b00000000 and any_req=0; r=8'b00000001 -> g=8'b00000001.
REQ-028: r=8'b10110000 -> g=8'b10000000; r=8'b00010110 -> g=8'b00010000; r=8'b11111111 -> g=8'b10000000.
REQ-029: rst_n=0 for 2 edges with r=8'hFF -> g_q=0, idx_q=0, valid_q=0, while g=8'b10000000; release, then one edge -> g_q=8'b10000000, idx_q=0, valid_q=1.
REQ-030: r=8'b00000100 held across an edge -> idx_q=5, valid_q=1; then r=0 and one edge -> g_q=0, idx_q=0, valid_q=0.
REQ-031: Parameter checks: n=1 with r toggled 0/1 -> g=r; n=3 exhaustive sweep -> matches the REQ-012 model.
